// File: rtl/uart_frame_arbiter.sv
// uart_frame_arbiter: round-robin arbiter that takes 32-bit words from up to
// four requesters and serialises each one as a framed byte stream into a
// single shared UART transmitter. The frame is a header, four data bytes
// (LSB first) and an 8'hAA trailer.
// Optional feature: define UART_ARB_CHECKSUM_EN to insert an XOR checksum
// byte ahead of the trailer, which makes the frame 7 bytes long.
module uart_frame_arbiter #(
    parameter int unsigned NUM_REQ = 4
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [NUM_REQ-1:0]   req_valid,
    input  logic [32*NUM_REQ-1:0] req_data,
    output logic [NUM_REQ-1:0]   req_ready,
    output logic [7:0]           tx_data,
    output logic                 tx_valid,
    input  logic                 tx_ready,
    output logic                 busy,
    output logic [1:0]           grant_id
);

    typedef enum logic {
        IDLE,
        SEND
    } state_t;

`ifdef UART_ARB_CHECKSUM_EN
    localparam logic [2:0] LAST_IDX = 3'd6;
`else
    localparam logic [2:0] LAST_IDX = 3'd5;
`endif

    state_t      state;
    state_t      state_nxt;
    logic [1:0]  last_grant;
    logic [1:0]  start;
    logic [1:0]  winner;
    logic        any_valid;
    logic [31:0] sel_word;
    logic [31:0] word;
    logic [2:0]  byte_idx;
    logic [7:0]  header;
    logic [7:0]  cur_byte;
    logic        take;
    logic        strobe;
    logic        frame_done;
`ifdef UART_ARB_CHECKSUM_EN
    logic [7:0]  checksum;
`endif

    // Round-robin pick: first valid at or above start, else first valid overall
    always_comb begin
        any_valid = 1'b0;
        winner    = '0;
        sel_word  = '0;
        if (32'(last_grant) >= NUM_REQ - 1) begin
            start = '0;
        end else begin
            start = last_grant + 2'd1;
        end
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            if (!any_valid && req_valid[i] && (i >= 32'(start))) begin
                any_valid = 1'b1;
                winner    = 2'(i);
                sel_word  = req_data[32*i +: 32];
            end
        end
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            if (!any_valid && req_valid[i]) begin
                any_valid = 1'b1;
                winner    = 2'(i);
                sel_word  = req_data[32*i +: 32];
            end
        end
    end

    // Frame byte selected by the current byte index
    always_comb begin
        header = {4'h5, 2'b00, grant_id};
`ifdef UART_ARB_CHECKSUM_EN
        checksum = header ^ word[7:0] ^ word[15:8] ^ word[23:16] ^ word[31:24];
`endif
        case (byte_idx)
            3'd0:    cur_byte = header;
            3'd1:    cur_byte = word[7:0];
            3'd2:    cur_byte = word[15:8];
            3'd3:    cur_byte = word[23:16];
            3'd4:    cur_byte = word[31:24];
`ifdef UART_ARB_CHECKSUM_EN
            3'd5:    cur_byte = checksum;
            3'd6:    cur_byte = 8'hAA;
`else
            3'd5:    cur_byte = 8'hAA;
`endif
            default: cur_byte = 8'h00;
        endcase
    end

    // Next state, handshake and strobe qualification
    always_comb begin
        state_nxt  = state;
        req_ready  = '0;
        take       = 1'b0;
        strobe     = 1'b0;
        frame_done = 1'b0;
        busy       = (state == SEND);
        case (state)
            IDLE: begin
                take = any_valid;
                for (int unsigned i = 0; i < NUM_REQ; i++) begin
                    req_ready[i] = rst_n && any_valid && (winner == 2'(i));
                end
                if (take) begin
                    state_nxt = SEND;
                end
            end
            SEND: begin
                strobe     = tx_ready && !tx_valid && (byte_idx <= LAST_IDX);
                frame_done = tx_valid && (byte_idx == LAST_IDX + 3'd1);
                if (frame_done) begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Word capture, grant pointer, byte index and registered byte strobe
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last_grant <= 2'(NUM_REQ - 1);
            grant_id   <= '0;
            word       <= '0;
            byte_idx   <= '0;
            tx_valid   <= 1'b0;
            tx_data    <= '0;
        end else begin
            tx_valid <= strobe;
            if (take) begin
                word       <= sel_word;
                grant_id   <= winner;
                last_grant <= winner;
                byte_idx   <= '0;
            end
            if (strobe) begin
                tx_data  <= cur_byte;
                byte_idx <= byte_idx + 3'd1;
            end
            if (frame_done) begin
                tx_data <= '0;
            end
        end
    end

endmodule

// File: tb/tb_uart_frame_arbiter.sv
// tb_uart_frame_arbiter: scoreboard bench for uart_frame_arbiter. Expected
// frame bytes are queued when a word is offered and checked as each tx_valid
// strobe arrives; a small UART model gates tx_ready.
module tb_uart_frame_arbiter;

    localparam int unsigned NUM_REQ = 4;
`ifdef UART_ARB_CHECKSUM_EN
    localparam int FRAME_LEN = 7;
`else
    localparam int FRAME_LEN = 6;
`endif

    logic                    clk = 1'b0;
    logic                    rst_n;
    logic [NUM_REQ-1:0]      req_valid;
    logic [32*NUM_REQ-1:0]   req_data;
    logic [NUM_REQ-1:0]      req_ready;
    logic [7:0]              tx_data;
    logic                    tx_valid;
    logic                    tx_ready;
    logic                    busy;
    logic [1:0]              grant_id;

    int         checks   = 0;
    int         failures = 0;
    int         strobes  = 0;
    logic       stall    = 1'b0;
    logic       prev_tv  = 1'b0;
    logic [7:0] exp_q[$];

    int s0;
    int s1;
    int viol;
    int gap;
    int phase;
    logic done;

    always #5 clk = ~clk;

    uart_frame_arbiter #(.NUM_REQ(NUM_REQ)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req_valid (req_valid),
        .req_data  (req_data),
        .req_ready (req_ready),
        .tx_data   (tx_data),
        .tx_valid  (tx_valid),
        .tx_ready  (tx_ready),
        .busy      (busy),
        .grant_id  (grant_id)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    function automatic void push_frame(input int id, input logic [31:0] w);
        logic [7:0] h;
        h = {4'h5, 2'b00, 2'(id)};
        exp_q.push_back(h);
        exp_q.push_back(w[7:0]);
        exp_q.push_back(w[15:8]);
        exp_q.push_back(w[23:16]);
        exp_q.push_back(w[31:24]);
`ifdef UART_ARB_CHECKSUM_EN
        exp_q.push_back(h ^ w[7:0] ^ w[15:8] ^ w[23:16] ^ w[31:24]);
`endif
        exp_q.push_back(8'hAA);
    endfunction

    // Scoreboard: every strobe pops one expected byte
    always @(negedge clk) begin
        if (tx_valid) begin
            strobes++;
            check("strobe_width", 32'(prev_tv), 32'd0);
            if (exp_q.size() == 0) begin
                check("unexpected_strobe", 32'(exp_q.size()), 32'd1);
            end else begin
                check("tx_byte", 32'(tx_data), 32'(exp_q.pop_front()));
            end
        end
        prev_tv = tx_valid;
    end

    // UART model: busy for two cycles after each strobe, held off while stalled
    initial begin
        tx_ready = 1'b1;
        forever begin
            @(negedge clk);
            if (tx_valid) begin
                tx_ready = 1'b0;
                repeat (2) @(negedge clk);
            end
            tx_ready = !stall;
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    task automatic wait_busy();
        logic ok;
        ok = 1'b0;
        for (int i = 0; i < 200 && !ok; i++) begin
            @(negedge clk);
            if (busy) ok = 1'b1;
        end
        if (!ok) check("busy_timeout", 32'(busy), 32'd1);
    endtask

    task automatic wait_idle();
        logic ok;
        ok = 1'b0;
        for (int i = 0; i < 3000 && !ok; i++) begin
            @(negedge clk);
            if (exp_q.size() == 0 && !busy) ok = 1'b1;
        end
        if (!ok) check("idle_timeout", 32'(exp_q.size()) + 32'(busy), 32'd0);
    endtask

    task automatic wait_queue_le(input int n);
        logic ok;
        ok = 1'b0;
        for (int i = 0; i < 3000 && !ok; i++) begin
            @(negedge clk);
            if (exp_q.size() <= n) ok = 1'b1;
        end
        if (!ok) check("queue_timeout", 32'(exp_q.size()), 32'(n));
    endtask

    task automatic send_one(input int id, input logic [31:0] w);
        req_data[32*id +: 32] = w;
        push_frame(id, w);
        req_valid[id] = 1'b1;
        #1;
        check("ready_onehot", 32'(req_ready), 32'(1) << id);
        wait_busy();
        req_valid[id] = 1'b0;
        req_data[32*id +: 32] = ~w;
        check("grant_id", 32'(grant_id), 32'(id));
        wait_idle();
        check("idle_busy", 32'(busy), 32'd0);
        check("idle_tx_data", 32'(tx_data), 32'd0);
    endtask

    task automatic pulse_reset();
        rst_n = 1'b0;
        exp_q.delete();
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        rst_n     = 1'b0;
        req_valid = 4'b1111;
        req_data  = '0;
        repeat (3) @(negedge clk);
        check("rst_req_ready", 32'(req_ready), 32'd0);
        check("rst_tx_valid",  32'(tx_valid),  32'd0);
        check("rst_tx_data",   32'(tx_data),   32'd0);
        check("rst_busy",      32'(busy),      32'd0);
        check("rst_grant_id",  32'(grant_id),  32'd0);
        req_valid = '0;
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check("idle_no_valid_ready", 32'(req_ready), 32'd0);

        // single requester, basic frame
        send_one(0, 32'h11223344);

        // all four held: grants 0,1,2,3,0
        pulse_reset();
        for (int i = 0; i < 4; i++) req_data[32*i +: 32] = 32'hA0B0C0D0 + 32'(i);
        for (int i = 0; i < 5; i++) push_frame(i % 4, 32'hA0B0C0D0 + 32'(i % 4));
        req_valid = 4'b1111;
        wait_queue_le(0);
        req_valid = '0;
        wait_idle();
        repeat (5) @(negedge clk);
        check("no_extra_frame", 32'(busy), 32'd0);

        // long tx_ready stall mid-frame
        req_data[63:32] = 32'hCAFE1234;
        push_frame(1, 32'hCAFE1234);
        req_valid = 4'b0010;
        wait_busy();
        req_valid = '0;
        wait_queue_le(FRAME_LEN - 2);
        stall = 1'b1;
        repeat (3) @(negedge clk);
        s0 = strobes;
        repeat (100) @(negedge clk);
        check("stall_strobes", 32'(strobes - s0), 32'd0);
        stall = 1'b0;
        wait_idle();

        // reset after the third strobe
        s0 = strobes;
        req_data[95:64] = 32'hDEADBEEF;
        push_frame(2, 32'hDEADBEEF);
        req_valid = 4'b0100;
        wait_busy();
        req_valid = '0;
        done = 1'b0;
        for (int i = 0; i < 200 && !done; i++) begin
            @(negedge clk);
            if (strobes - s0 >= 3) done = 1'b1;
        end
        check("third_strobe_seen", 32'(strobes - s0), 32'd3);
        rst_n = 1'b0;
        exp_q.delete();
        s1 = strobes;
        req_valid = 4'b0100;
        #1;
        check("midrst_req_ready", 32'(req_ready), 32'd0);
        repeat (3) @(negedge clk);
        check("midrst_tx_valid", 32'(tx_valid), 32'd0);
        check("midrst_tx_data",  32'(tx_data),  32'd0);
        check("midrst_busy",     32'(busy),     32'd0);
        check("midrst_grant_id", 32'(grant_id), 32'd0);
        check("midrst_strobes",  32'(strobes - s1), 32'd0);
        req_data[95:64] = 32'h0BADF00D;
        push_frame(2, 32'h0BADF00D);
        rst_n = 1'b1;
        #1;
        check("release_no_early_xfer", 32'(busy), 32'd0);
        wait_busy();
        req_valid = '0;
        check("post_rst_grant", 32'(grant_id), 32'd2);
        wait_idle();

        // requester 2 held off during requester 0's frame
        req_data[31:0]  = 32'h01020304;
        req_data[95:64] = 32'h05060708;
        push_frame(0, 32'h01020304);
        push_frame(2, 32'h05060708);
        req_valid = 4'b0001;
        wait_busy();
        req_valid = 4'b0100;
        viol  = 0;
        gap   = 0;
        phase = 0;
        for (int i = 0; i < 2000 && phase < 2; i++) begin
            @(negedge clk);
            if (busy && req_ready != '0) viol++;
            if (phase == 0 && !busy) begin
                phase = 1;
                check("idle_ready_r2", 32'(req_ready), 32'h4);
            end
            if (phase == 1) begin
                if (busy) phase = 2;
                else gap++;
            end
        end
        req_valid = '0;
        check("held_off_ready", 32'(viol), 32'd0);
        check("frame_gap", 32'(gap), 32'd1);
        check("second_grant", 32'(grant_id), 32'd2);
        wait_idle();

        // checksum example data
        send_one(1, 32'h000000FF);

        check("queue_drained", 32'(exp_q.size()), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/uart_frame_arbiter.md
UART_FRAME_ARBITER -- requirements
Module: uart_frame_arbiter

Interface
REQ-001 Parameter NUM_REQ, default 4, number of requesters; legal range 1..4.
REQ-002 Port clk  input  1  system clock; all state updates on its rising edge.
REQ-003 Port rst_n  input  1  reset, asynchronous, active-low.
REQ-004 Port req_valid  input  NUM_REQ  per-requester word-available flag.
REQ-005 Port req_data  input  32*NUM_REQ  requester i word on bits [32*i+31:32*i].
REQ-006 Port req_ready  output  NUM_REQ  one-hot accept; word i transfers when req_valid[i] && req_ready[i].
REQ-007 Port tx_data  output  8  byte presented to the shared UART transmitter.
REQ-008 Port tx_valid  output  1  single-cycle byte strobe to the transmitter.
REQ-009 Port tx_ready  input  1  transmitter idle flag; drops the cycle after an accepted strobe.
REQ-010 Port busy  output  1  high while a frame is in progress.
REQ-011 Port grant_id  output  2  index of the requester owning the current or last frame.

Function
REQ-012 The block shall have two states, IDLE and SEND, plus a byte index 0..5 (0..6 with checksum).
REQ-013 In IDLE, req_ready shall be combinational: one-hot on the winning requester among those with req_valid high, all zero if none; req_ready shall be zero in SEND.
REQ-014 Arbitration shall be round-robin: search starts at (last grant + 1) mod NUM_REQ; last grant resets to NUM_REQ-1, so requester 0 wins first.
REQ-015 On transfer, the block shall latch the word and the index into grant_id, set byte index 0, enter SEND, and set busy, all on the same edge.
REQ-016 Frame byte order shall be: header {4'h5,2'b00,grant_id}; word[7:0]; word[15:8]; word[23:16]; word[31:24]; trailer 8'hAA.
REQ-017 In SEND, tx_valid shall be registered and asserted for exactly one cycle when tx_ready is 1 and tx_valid was 0 in the previous cycle; the byte index shall advance on that edge.
REQ-018 tx_data shall equal the byte selected by the current index whenever tx_valid is 1; it is 8'h00 in IDLE.
REQ-019 After the trailer strobe, the block shall return to IDLE on the next edge, clear busy, and be able to accept a new word in that same IDLE cycle.
REQ-020 Requests arriving during SEND shall be held off (req_ready 0) and shall not be lost; they shall be arbitrated on return to IDLE.
REQ-021 A requester dropping req_valid without a transfer shall have no effect; latched data shall be immune to req_data changes after transfer.
REQ-022 With NUM_REQ=1, requester 0 shall always win; the round-robin pointer shall stay at 0.
REQ-023 Minimum frame time shall be 6 tx_ready-gated strobes; back-to-back frames shall insert no extra idle bytes.

Reset
REQ-024 While rst_n is 0, outputs shall be: req_ready 0, tx_valid 0, tx_data 8'h00, busy 0, grant_id 0; state IDLE; pointer NUM_REQ-1.
REQ-025 Reset asserted mid-frame shall abort the frame immediately, with no further strobes; the remaining bytes are discarded.
REQ-026 After release, the first transfer shall occur no earlier than the first rising edge with rst_n high.

Configuration
REQ-027 Macro UART_ARB_CHECKSUM_EN defined: a checksum byte, the XOR of header and the four data bytes, shall be sent between word[31:24] and the trailer (7-byte frame, index 0..6).
REQ-028 Macro UART_ARB_CHECKSUM_EN undefined: frames shall be exactly the 6 bytes of REQ-016, and no checksum logic shall be present.

Verification
REQ-029 Scenario: NUM_REQ=4, req_valid=4'b0001, data 0x11223344, tx_ready modelled as the UART -> bytes 0x50,0x44,0x33,0x22,0x11,0xAA, then busy 0.
REQ-030 Scenario: all four valid simultaneously after reset, held -> grant order 0,1,2,3,0; headers 0x50,0x51,0x52,0x53,0x50.
REQ-031 Scenario: tx_ready held 0 for 100 cycles mid-frame -> no tx_valid during the stall; the sequence resumes with the correct next byte.
REQ-032 Scenario: rst_n pulsed low after the third strobe -> no further strobes, outputs at REQ-024 values; the next request starts a fresh frame with its header.
REQ-033 Scenario: requester 2 valid during SEND of requester 0's frame -> req_ready[2] stays 0 until IDLE, then frame with header 0x52 follows without gap.
REQ-034 Scenario: UART_ARB_CHECKSUM_EN defined, requester 1 data 0x000000FF -> bytes 0x51,0xFF,0x00,0x00,0x00,0xAE,0xAA.
